cp0_exc_sequencer: RTL and testbench
====================================

// Module: cp0_exc_sequencer
// PURPOSE
//  Sequences exception entry and ERET return around the CP0 register file; sits between decode and CP0.
//  Takes syscall/break/teq requests from decode and applies STATUS masks.
//  Serialises the result into single-cycle exception/eret strobes to CP0, a pipeline flush and a PC redirect.
// PARAMETERS
//  HANDLER_ADDR  32'h00400004  exception vector driven on redirect_addr
//  C_SYSCALL     5'b01000      cause code for syscall
//  C_BREAK       5'b01001      cause code for break
//  C_TEQ         5'b01101      cause code for teq trap
//  C_INT         5'b00000      cause code for external interrupt (CP0_EXC_IRQ_EN only)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  syscall_req    in   1   decode: syscall in ID stage
//  break_req      in   1   decode: break in ID stage
//  teq_req        in   1   decode: teq with rs==rt
//  eret_req       in   1   decode: eret in ID stage
//  mtc0_busy      in   1   CP0 write in progress this cycle (CP0 gives mtc0 priority)
//  pc_id          in   32  PC of the requesting instruction
//  status         in   32  CP0 STATUS; [0]=IE, [1]=syscall, [2]=break, [3]=teq, [4]=int enable
//  epc            in   32  CP0 EPC read value
//  irq            in   1   external interrupt, level (CP0_EXC_IRQ_EN only)
//  cp0_exception  out  1   exception strobe to CP0
//  cp0_eret       out  1   eret strobe to CP0
//  cp0_cause      out  5   cause code to CP0
//  cp0_pc         out  32  PC written to EPC
//  flush          out  1   kill IF/ID contents
//  redirect       out  1   load redirect_addr into PC
//  redirect_addr  out  32  new PC
//  busy           out  1   stall fetch/decode
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; latched cause/pc 0. Reset mid-sequence aborts; no strobe completes.
//  - FSM states: IDLE, SAVE, RESTORE, VECTOR.
//  - IDLE: a request is taken only if enabled: status[0] & the matching mask bit. Priority: break > syscall > teq > irq.
//    On a taken request: latch cause and pc_id, then go to SAVE.
//    Else if eret_req: go to RESTORE.
//    Masked requests are dropped silently. An exception wins over a simultaneous eret.
//  - SAVE: busy=1, flush=1. If mtc0_busy: hold in SAVE with cp0_exception=0.
//    Else cp0_exception=1 for exactly one cycle with cp0_cause and cp0_pc=latched values, then go to VECTOR.
//  - RESTORE: busy=1, flush=1. If mtc0_busy: hold. Else cp0_eret=1 for one cycle, latch epc, then go to VECTOR.
//  - VECTOR: redirect=1 for one cycle; busy=1. Then return to IDLE.
//    redirect_addr = HANDLER_ADDR after SAVE, or the latched EPC after RESTORE.
//  - Latency: request edge -> strobe next cycle (no mtc0 conflict) -> redirect the cycle after. Total 2 cycles busy.
//  - Requests arriving outside IDLE are ignored; decode is stalled by busy.
//  - All outputs are registered: no combinational path from inputs to outputs.
//  - cp0_cause and cp0_pc are 0 except in the SAVE strobe cycle.
// CONFIGURATION
//  CP0_EXC_IRQ_EN defined:
//  - irq is sampled in IDLE with lowest priority, gated by status[0]&status[4].
//  - cause=C_INT; cp0_pc=pc_id, so the interrupted instruction is re-executed after eret.
//  CP0_EXC_IRQ_EN undefined: irq port exists but is ignored; status[4] is unused.
// STRUCTURE
//  - Shared package/include cp0_defs: cause codes, STATUS bit indices, HANDLER_ADDR and FSM state encodings.
//    These are shared with CP0 and the decoder.
//  - One sub-module, cp0_exc_prio: combinational priority/mask encoder producing a taken flag and cause.
//    The FSM stays in the top.
// TESTING
//  1. status=0x0F, syscall_req, pc_id=0x00400100:
//     -> next cycle cp0_exception=1, cause=C_SYSCALL, cp0_pc=0x00400100.
//     -> following cycle redirect=1, redirect_addr=0x00400004.
//  2. status=0x0D (syscall masked), syscall_req -> no strobe, busy stays 0.
//     Same cycle with break_req -> cause=C_BREAK.
//  3. break_req+syscall_req+eret_req together -> cause=C_BREAK; cp0_eret never asserted.
//  4. eret_req, epc=0x00400200 -> cp0_eret 1 cycle, then redirect to 0x00400200.
//  5. syscall taken with mtc0_busy held 3 cycles -> SAVE held 3 cycles, then strobe. busy=1 throughout.
//  6. rst pulsed during SAVE -> all outputs 0 same cycle. IDLE after release; no strobe/redirect.
//     With CP0_EXC_IRQ_EN: irq=1, status=0x11 -> cause=C_INT.

Source files
------------

// File: rtl/cp0_exc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cp0_exc_sequencer_pkg
// Definitions shared by CP0, the decoder and the exception sequencer:
//   - exception cause codes written into CP0 CAUSE
//   - bit positions of the enable fields inside CP0 STATUS
//   - the exception handler vector
//   - the exception sequencer state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package cp0_exc_sequencer_pkg;

    // Cause codes
    localparam logic [4:0] C_SYSCALL = 5'b01000;
    localparam logic [4:0] C_BREAK   = 5'b01001;
    localparam logic [4:0] C_TEQ     = 5'b01101;
    localparam logic [4:0] C_INT     = 5'b00000;

    // STATUS bit indices
    localparam logic [2:0] STATUS_IE  = 3'd0;
    localparam logic [2:0] STATUS_SYS = 3'd1;
    localparam logic [2:0] STATUS_BRK = 3'd2;
    localparam logic [2:0] STATUS_TEQ = 3'd3;
    localparam logic [2:0] STATUS_INT = 3'd4;

    // Exception vector
    localparam logic [31:0] CP0_HANDLER_ADDR = 32'h0040_0004;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_VECTOR  = 2'd3
    } exc_state_e;

endpackage

// File: rtl/cp0_exc_sequencer_prio.sv
// ----------------------------------------------------------------------------
// cp0_exc_sequencer_prio
// Combinational priority/mask encoder for exception requests.
// A request counts only when STATUS.IE and its own enable bit are set.
// Priority: break > syscall > teq > irq.
// Configuration macro: CP0_EXC_IRQ_EN -- when defined, irq participates at the
// lowest priority gated by STATUS[4]; otherwise irq and STATUS[4] are ignored.
// Ports:
//   syscall_req, break_req, teq_req, irq  in   request lines
//   status                                in   STATUS[4:0] enable bits
//   taken                                 out  some enabled request present
//   cause                                 out  cause code of the winner (0 if none)
// ----------------------------------------------------------------------------
module cp0_exc_sequencer_prio
    import cp0_exc_sequencer_pkg::*;
(
    input  logic       syscall_req,
    input  logic       break_req,
    input  logic       teq_req,
    input  logic       irq,
    input  logic [4:0] status,
    output logic       taken,
    output logic [4:0] cause
);

    logic irq_take_s;

`ifdef CP0_EXC_IRQ_EN
    assign irq_take_s = irq & status[STATUS_INT];
`else
    // irq and the interrupt enable exist on the interface but have no effect
    logic unused_irq_s;
    assign unused_irq_s = irq ^ status[STATUS_INT];
    assign irq_take_s   = 1'b0;
`endif

    // Masked priority selection of the winning request
    always_comb begin
        taken = 1'b0;
        cause = 5'd0;
        if (!status[STATUS_IE]) begin
            taken = 1'b0;
            cause = 5'd0;
        end else if (break_req && status[STATUS_BRK]) begin
            taken = 1'b1;
            cause = C_BREAK;
        end else if (syscall_req && status[STATUS_SYS]) begin
            taken = 1'b1;
            cause = C_SYSCALL;
        end else if (teq_req && status[STATUS_TEQ]) begin
            taken = 1'b1;
            cause = C_TEQ;
        end else if (irq_take_s) begin
            taken = 1'b1;
            cause = C_INT;
        end else begin
            taken = 1'b0;
            cause = 5'd0;
        end
    end

endmodule

// File: rtl/cp0_exc_sequencer.sv
// ----------------------------------------------------------------------------
// cp0_exc_sequencer
// Sequences exception entry and ERET return around the CP0 register file.
// Decode requests are masked/prioritised, then serialised into single-cycle
// exception/eret strobes to CP0, a pipeline flush and a PC redirect.
// Configuration macro: CP0_EXC_IRQ_EN (external interrupt as lowest-priority
// exception source, handled inside cp0_exc_sequencer_prio).
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   syscall_req/break_req/
//   teq_req/eret_req          decode requests from the ID stage
//   mtc0_busy                 CP0 write in progress; delays our strobes
//   pc_id                     PC of the requesting instruction
//   status, epc               CP0 STATUS and EPC read values
//   irq                       external interrupt level
//   cp0_exception/cp0_eret    single-cycle strobes to CP0
//   cp0_cause/cp0_pc          cause and EPC value, non-zero only with the strobe
//   flush, redirect,
//   redirect_addr, busy       pipeline control
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module cp0_exc_sequencer
    import cp0_exc_sequencer_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = CP0_HANDLER_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        syscall_req,
    input  logic        break_req,
    input  logic        teq_req,
    input  logic        eret_req,
    input  logic        mtc0_busy,
    input  logic [31:0] pc_id,
    input  logic [31:0] status,
    input  logic [31:0] epc,
    input  logic        irq,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_addr,
    output logic        busy
);

    exc_state_e  state_q, state_d;
    logic [4:0]  lat_cause_q, lat_cause_d;
    logic [31:0] lat_pc_q, lat_pc_d;
    logic [31:0] epc_q, epc_d;
    logic        exc_q, exc_d;
    logic        eret_q, eret_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [31:0] raddr_q, raddr_d;
    logic        busy_q, busy_d;

    logic        taken_s;
    logic [4:0]  prio_cause_s;

    // Upper STATUS bits belong to other CP0 features
    logic unused_status_s;
    assign unused_status_s = ^status[31:5];

    cp0_exc_sequencer_prio u_prio (
        .syscall_req (syscall_req),
        .break_req   (break_req),
        .teq_req     (teq_req),
        .irq         (irq),
        .status      (status[4:0]),
        .taken       (taken_s),
        .cause       (prio_cause_s)
    );

    // Next-state and next-output computation. Output flops are loaded with the
    // values for the coming cycle, so a strobe decided at a given edge appears
    // in the cycle right after it. exc_q/eret_q being set inside SAVE/RESTORE
    // marks that the strobe cycle is in progress and the next edge moves on.
    always_comb begin
        state_d     = state_q;
        lat_cause_d = lat_cause_q;
        lat_pc_d    = lat_pc_q;
        epc_d       = epc_q;
        exc_d       = 1'b0;
        eret_d      = 1'b0;
        cause_d     = 5'd0;
        pc_d        = 32'd0;
        redirect_d  = 1'b0;
        raddr_d     = 32'd0;
        flush_d     = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // An enabled exception beats a simultaneous eret
                if (taken_s) begin
                    lat_cause_d = prio_cause_s;
                    lat_pc_d    = pc_id;
                    state_d     = ST_SAVE;
                    exc_d       = !mtc0_busy;
                end else if (eret_req) begin
                    state_d = ST_RESTORE;
                    eret_d  = !mtc0_busy;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                if (exc_q) begin
                    state_d    = ST_VECTOR;
                    redirect_d = 1'b1;
                    raddr_d    = HANDLER_ADDR;
                end else if (mtc0_busy) begin
                    state_d = ST_SAVE;
                end else begin
                    exc_d = 1'b1;
                end
            end
            ST_RESTORE: begin
                // EPC is captured at the end of the eret strobe cycle
                if (eret_q) begin
                    state_d    = ST_VECTOR;
                    epc_d      = epc;
                    redirect_d = 1'b1;
                    raddr_d    = epc_d;
                end else if (mtc0_busy) begin
                    state_d = ST_RESTORE;
                end else begin
                    eret_d = 1'b1;
                end
            end
            ST_VECTOR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cause/PC are presented only alongside the exception strobe
        if (exc_d) begin
            cause_d = lat_cause_d;
            pc_d    = lat_pc_d;
        end else begin
            cause_d = 5'd0;
            pc_d    = 32'd0;
        end

        busy_d  = (state_d != ST_IDLE);
        flush_d = (state_d == ST_SAVE) || (state_d == ST_RESTORE);
    end

    // State, latched request data and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_cause_q <= 5'd0;
            lat_pc_q    <= 32'd0;
            epc_q       <= 32'd0;
            exc_q       <= 1'b0;
            eret_q      <= 1'b0;
            cause_q     <= 5'd0;
            pc_q        <= 32'd0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            raddr_q     <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cause_q <= lat_cause_d;
            lat_pc_q    <= lat_pc_d;
            epc_q       <= epc_d;
            exc_q       <= exc_d;
            eret_q      <= eret_d;
            cause_q     <= cause_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            raddr_q     <= raddr_d;
            busy_q      <= busy_d;
        end
    end

    assign cp0_exception = exc_q;
    assign cp0_eret      = eret_q;
    assign cp0_cause     = cause_q;
    assign cp0_pc        = pc_q;
    assign flush         = flush_q;
    assign redirect      = redirect_q;
    assign redirect_addr = raddr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cp0_exc_sequencer
// Directed stimulus pushes expected CP0 strobes / redirects (with the cycle
// they must appear in) into a queue; an independent monitor pops and compares
// whenever the DUT raises cp0_exception, cp0_eret or redirect.
// ----------------------------------------------------------------------------
module tb_cp0_exc_sequencer;
    import cp0_exc_sequencer_pkg::*;

    localparam int K_EXC   = 0;
    localparam int K_ERET  = 1;
    localparam int K_REDIR = 2;

    typedef struct {
        int          kind;
        logic [4:0]  cause;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        syscall_req, break_req, teq_req, eret_req, mtc0_busy, irq;
    logic [31:0] pc_id, status, epc;
    logic        cp0_exception, cp0_eret, flush, redirect, busy;
    logic [4:0]  cp0_cause;
    logic [31:0] cp0_pc, redirect_addr;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    cp0_exc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .syscall_req   (syscall_req),
        .break_req     (break_req),
        .teq_req       (teq_req),
        .eret_req      (eret_req),
        .mtc0_busy     (mtc0_busy),
        .pc_id         (pc_id),
        .status        (status),
        .epc           (epc),
        .irq           (irq),
        .cp0_exception (cp0_exception),
        .cp0_eret      (cp0_eret),
        .cp0_cause     (cp0_cause),
        .cp0_pc        (cp0_pc),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int kind, input logic [4:0] cause, input logic [31:0] addr, input int c);
        exp_t e;
        e.kind  = kind;
        e.cause = cause;
        e.addr  = addr;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    task automatic take_event(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got event kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = sb.pop_front();
            check32("event_kind", kind, e.kind);
            check32("event_cycle", cyc, e.cyc);
            if (kind == K_EXC) begin
                check32("exc_cause", {27'd0, cp0_cause}, {27'd0, e.cause});
                check32("exc_pc", cp0_pc, e.addr);
            end
            if (kind == K_REDIR) begin
                check32("redirect_addr", redirect_addr, e.addr);
            end
        end
    endtask

    // Monitor: compare every strobe/redirect against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (cp0_exception) take_event(K_EXC);
            if (cp0_eret)      take_event(K_ERET);
            if (redirect)      take_event(K_REDIR);
            if (!cp0_exception) check32("cause_pc_zero", {27'd0, cp0_cause} | cp0_pc, 32'd0);
        end
    end

    task automatic clear_reqs();
        syscall_req = 1'b0;
        break_req   = 1'b0;
        teq_req     = 1'b0;
        eret_req    = 1'b0;
        irq         = 1'b0;
    endtask

    task automatic check_ctl(input string name, input logic b, input logic f);
        check32({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        check32({name, "_flush"}, {31'd0, flush}, {31'd0, f});
    endtask

    task automatic check_all_zero(input string name);
        check32({name, "_strobes"}, {28'd0, cp0_exception, cp0_eret, redirect, busy}, 32'd0);
        check32({name, "_flush"}, {31'd0, flush}, 32'd0);
        check32({name, "_cause"}, {27'd0, cp0_cause}, 32'd0);
        check32({name, "_pc"}, cp0_pc, 32'd0);
        check32({name, "_raddr"}, redirect_addr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b1;
        clear_reqs();
        mtc0_busy = 1'b0;
        pc_id     = 32'd0;
        status    = 32'h0000_000F;
        epc       = 32'd0;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: syscall taken, then redirect to the handler
        @(negedge clk);
        n = cyc;
        status = 32'h0000_000F; pc_id = 32'h0040_0100; syscall_req = 1'b1;
        push(K_EXC, C_SYSCALL, 32'h0040_0100, n + 1);
        push(K_REDIR, 5'd0, 32'h0040_0004, n + 2);
        @(negedge clk); clear_reqs(); check_ctl("t1_save", 1'b1, 1'b1);
        @(negedge clk); check_ctl("t1_vector", 1'b1, 1'b0);
        @(negedge clk); check_ctl("t1_idle", 1'b0, 1'b0);

        // 2a: syscall masked -> dropped
        @(negedge clk);
        status = 32'h0000_000D; pc_id = 32'h0040_0110; syscall_req = 1'b1;
        @(negedge clk); clear_reqs(); check_ctl("t2_masked", 1'b0, 1'b0);
        // 2b: masked syscall alongside break -> break wins
        n = cyc;
        pc_id = 32'h0040_0120; syscall_req = 1'b1; break_req = 1'b1;
        push(K_EXC, C_BREAK, 32'h0040_0120, n + 1);
        push(K_REDIR, 5'd0, 32'h0040_0004, n + 2);
        @(negedge clk); clear_reqs();
        repeat (3) @(negedge clk);

        // 3: break + syscall + eret -> break, no eret
        n = cyc;
        status = 32'h0000_000F; pc_id = 32'h0040_0300; epc = 32'h0040_0900;
        break_req = 1'b1; syscall_req = 1'b1; eret_req = 1'b1;
        push(K_EXC, C_BREAK, 32'h0040_0300, n + 1);
        push(K_REDIR, 5'd0, 32'h0040_0004, n + 2);
        @(negedge clk); clear_reqs();
        repeat (3) @(negedge clk);

        // 3b: teq taken; then teq masked
        n = cyc;
        pc_id = 32'h0040_0310; teq_req = 1'b1;
        push(K_EXC, C_TEQ, 32'h0040_0310, n + 1);
        push(K_REDIR, 5'd0, 32'h0040_0004, n + 2);
        @(negedge clk); clear_reqs();
        repeat (3) @(negedge clk);
        status = 32'h0000_0007; teq_req = 1'b1;
        @(negedge clk); clear_reqs(); check_ctl("t3_teq_masked", 1'b0, 1'b0);
        status = 32'h0000_000F;

        // 4: eret -> eret strobe, redirect to EPC
        @(negedge clk);
        n = cyc;
        epc = 32'h0040_0200; eret_req = 1'b1;
        push(K_ERET, 5'd0, 32'd0, n + 1);
        push(K_REDIR, 5'd0, 32'h0040_0200, n + 2);
        @(negedge clk); clear_reqs(); check_ctl("t4_restore", 1'b1, 1'b1);
        @(negedge clk); check_ctl("t4_vector", 1'b1, 1'b0);
        @(negedge clk); check_ctl("t4_idle", 1'b0, 1'b0);

        // 5: syscall with mtc0_busy for 3 cycles -> strobe delayed by 3
        n = cyc;
        pc_id = 32'h0040_0400; syscall_req = 1'b1; mtc0_busy = 1'b1;
        push(K_EXC, C_SYSCALL, 32'h0040_0400, n + 4);
        push(K_REDIR, 5'd0, 32'h0040_0004, n + 5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) clear_reqs();
            if (k == 3) mtc0_busy = 1'b0;
            check_ctl("t5_hold", 1'b1, (k <= 4) ? 1'b1 : 1'b0);
        end
        @(negedge clk); check_ctl("t5_idle", 1'b0, 1'b0);

        // 6: reset during SAVE aborts the sequence
        n = cyc;
        pc_id = 32'h0040_0500; syscall_req = 1'b1; mtc0_busy = 1'b1;
        @(negedge clk); clear_reqs(); check_ctl("t6_save", 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        @(negedge clk);
        rst = 1'b0; mtc0_busy = 1'b0;
        repeat (3) @(negedge clk);
        check_ctl("t6_after", 1'b0, 1'b0);
        // Back in IDLE: a fresh eret sequences normally
        n = cyc;
        epc = 32'h0040_0600; eret_req = 1'b1;
        push(K_ERET, 5'd0, 32'd0, n + 1);
        push(K_REDIR, 5'd0, 32'h0040_0600, n + 2);
        @(negedge clk); clear_reqs();
        repeat (3) @(negedge clk);

        // 7: external interrupt
        n = cyc;
        status = 32'h0000_0011; pc_id = 32'h0040_0700; irq = 1'b1;
`ifdef CP0_EXC_IRQ_EN
        push(K_EXC, C_INT, 32'h0040_0700, n + 1);
        push(K_REDIR, 5'd0, 32'h0040_0004, n + 2);
        @(negedge clk); clear_reqs(); check_ctl("t7_irq", 1'b1, 1'b1);
`else
        @(negedge clk); clear_reqs(); check_ctl("t7_irq_ignored", 1'b0, 1'b0);
`endif
        repeat (4) @(negedge clk);

        check32("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
